ryuki_if_tracer: RTL and testbench
==================================

# ryuki_if_tracer

Cycle-accurate instruction-fetch tracer for the Ryuki core. It follows one fetch at a time through the IF stage and its instruction-memory access, stamping start and end cycles from a free-running counter. Each completed fetch becomes a trace record (instruction, address, IF interval, memory-access interval), buffered in a DEPTH-entry FIFO and drained over a valid/ready port. Sits beside the IF stage as a passive observer and never back-pressures the core.

## Interface
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, fetch address width
- TIME_WIDTH, 32, timestamp width; counter wraps modulo 2^TIME_WIDTH
- DEPTH, 8, FIFO entries; power of two, ≥2
- OVF_WIDTH, 16, overflow counter width
- clk  in  1  core clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- fetch_req  in  1  IF stage issues a fetch this cycle
- fetch_addr  in  ADDR_WIDTH  address of the fetch, valid with fetch_req
- mem_gnt  in  1  instruction memory grants the request
- mem_rvalid  in  1  instruction memory returns data
- mem_rdata  in  DATA_WIDTH  instruction word, valid with mem_rvalid
- if_done  in  1  instruction handed from IF to ID
- trace_valid  out  1  head record available
- trace_ready  in  1  consumer accepts head record
- trace_instr  out  DATA_WIDTH  head record instruction
- trace_addr  out  ADDR_WIDTH  head record address
- trace_if_start / trace_if_end  out  TIME_WIDTH each  IF interval
- trace_mem_start / trace_mem_end  out  TIME_WIDTH each  memory-access interval
- trace_count  out  $clog2(DEPTH)+1  FIFO occupancy
- trace_overflow  out  OVF_WIDTH  records dropped, saturating

## Operation
- Cycle counter `now`: 0 in the first cycle after reset release, +1 every cycle, wraps silently.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID, WAIT_DONE.
- IDLE: on fetch_req latch fetch_addr and if_start=now. If mem_gnt is high in the same cycle, set mem_start=now and go to WAIT_RVALID. Otherwise go to WAIT_GNT. fetch_req outside IDLE is ignored.
- WAIT_GNT: on mem_gnt set mem_start=now and go to WAIT_RVALID.
- WAIT_RVALID: on mem_rvalid latch mem_rdata and set mem_end=now. If if_done is high in the same cycle, set if_end=now and complete. Otherwise go to WAIT_DONE.
- WAIT_DONE: on if_done set if_end=now and complete.
- Complete: return to IDLE and push the record. A new fetch_req is accepted in the IDLE cycle that follows.
- Push while the FIFO is full and not popping: the record is dropped and trace_overflow increments, saturating at all-ones. The FSM never stalls.
- Pop: trace_valid && trace_ready.
- Push while full with a pop in the same cycle: both take effect and occupancy stays at DEPTH.
- Timestamps are raw counter values. The consumer handles wrap; end < start is legal after a wrap.

## Timing
- Reset values: trace_valid=0, trace_count=0, trace_overflow=0, all trace data outputs 0, FSM=IDLE, now=0.
- Reset mid-operation discards the in-flight record and all FIFO contents.
- Push-to-output latency is 1 cycle: record completed in cycle t gives trace_valid=1 in cycle t+1 when the FIFO was empty.
- Head outputs are registered and stay stable while trace_valid && !trace_ready.
- trace_count and trace_overflow update in the cycle after the push or pop.
- Minimum fetch duration is 1 cycle: mem_gnt and fetch_req in cycle t, mem_rvalid and if_done in t+1.

## Structure
- Add to package ryuki_datatypes:
  - struct trace_record {instr, addr, if_start, if_end, mem_start, mem_end}, sized from `DATA_WIDTH`, `ADDR_WIDTH` and a new `TIME_WIDTH` define in ryuki_defines.
  - Enum if_tracer_state_t for the four FSM states.
- Sub-module ryuki_trace_fifo: generic synchronous FIFO (WIDTH, DEPTH) with registered head, count output, and simultaneous push/pop when full.

## Test plan
- Reset release, then fetch_req+mem_gnt at now=3 (addr 0x100), mem_rvalid (rdata 0x00000013) at 5, if_done at 7 → record {0x13, 0x100, if 3–7, mem 3–5}; trace_valid at cycle 8.
- Fetch with mem_gnt delayed to now=6 after req at 4, rvalid and if_done together at 9 → record {if 4–9, mem 6–9}.
- DEPTH=8, trace_ready=0, ten complete fetches → trace_count=8, trace_overflow=2; the first eight records drain in order.
- FIFO full, trace_ready=1 in the same cycle as a completion → no overflow increment, trace_count stays 8.
- TIME_WIDTH=4, fetch spanning now=14 to 2 → if_start=14, if_end=2.
- rst_n low in WAIT_RVALID with 3 records queued → next cycle trace_valid=0, trace_count=0, trace_overflow=0; a later rvalid produces no record.

Source files
------------

// File: rtl/ryuki_if_tracer_pkg.sv
// Shared types and default sizes for the Ryuki instruction-fetch tracer.
package ryuki_if_tracer_pkg;

  localparam int unsigned RYUKI_DATA_WIDTH = 32;
  localparam int unsigned RYUKI_ADDR_WIDTH = 32;
  localparam int unsigned RYUKI_TIME_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2,
    WAIT_DONE   = 2'd3
  } if_tracer_state_t;

endpackage

// File: rtl/ryuki_trace_fifo.sv
// Synchronous FIFO with a registered head entry; accepts push and pop together when full.
module ryuki_trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_next;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full, pop, push_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop     = pop_i && (count_q != '0);
  assign push_ok = push_i && (!full || pop);
  assign drop_o  = push_i && full && !pop;
  assign rd_next = rd_ptr_q + PTR_W'(1);

  assign valid_o = (count_q != '0);
  assign head_o  = head_q;
  assign count_o = count_q;

  always_comb begin
    rd_ptr_d = pop ? rd_next : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Head mirrors mem_q[rd_ptr]; a lone entry being popped hands over straight to the incoming push
    head_d = head_q;
    if (pop) begin
      if (count_q == CNT_W'(1)) begin
        if (push_ok) head_d = data_i;
      end else begin
        head_d = mem_q[rd_next];
      end
    end else if ((count_q == '0) && push_ok) begin
      head_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/ryuki_if_tracer.sv
// Passive IF-stage observer: timestamps one fetch at a time and queues a trace record per fetch.
module ryuki_if_tracer
  import ryuki_if_tracer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RYUKI_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RYUKI_ADDR_WIDTH,
  parameter int unsigned TIME_WIDTH = RYUKI_TIME_WIDTH,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned OVF_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_req,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    if_done,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [DATA_WIDTH-1:0]   trace_instr,
  output logic [ADDR_WIDTH-1:0]   trace_addr,
  output logic [TIME_WIDTH-1:0]   trace_if_start,
  output logic [TIME_WIDTH-1:0]   trace_if_end,
  output logic [TIME_WIDTH-1:0]   trace_mem_start,
  output logic [TIME_WIDTH-1:0]   trace_mem_end,
  output logic [$clog2(DEPTH):0]  trace_count,
  output logic [OVF_WIDTH-1:0]    trace_overflow
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [TIME_WIDTH-1:0] if_start;
    logic [TIME_WIDTH-1:0] if_end;
    logic [TIME_WIDTH-1:0] mem_start;
    logic [TIME_WIDTH-1:0] mem_end;
  } trace_record_t;

  localparam int unsigned REC_W = $bits(trace_record_t);

  if_tracer_state_t      state_q, state_d;
  logic [TIME_WIDTH-1:0] now_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [TIME_WIDTH-1:0] if_start_q, mem_start_q, mem_end_q;
  logic [OVF_WIDTH-1:0]  ovf_q;

  logic          cap_fetch, cap_gnt, cap_rvalid, push, drop, fifo_valid;
  trace_record_t push_rec, head_rec;
  logic [REC_W-1:0] head_bits;

  always_ff @(posedge clk) begin
    if (!rst_n) now_q <= '0;
    else        now_q <= now_q + TIME_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (fetch_req)  state_d = mem_gnt ? WAIT_RVALID : WAIT_GNT;
      WAIT_GNT:    if (mem_gnt)    state_d = WAIT_RVALID;
      WAIT_RVALID: if (mem_rvalid) state_d = if_done ? IDLE : WAIT_DONE;
      WAIT_DONE:   if (if_done)    state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_fetch  = (state_q == IDLE) && fetch_req;
    cap_gnt    = mem_gnt && (((state_q == IDLE) && fetch_req) || (state_q == WAIT_GNT));
    cap_rvalid = (state_q == WAIT_RVALID) && mem_rvalid;
    push       = ((state_q == WAIT_RVALID) && mem_rvalid && if_done) ||
                 ((state_q == WAIT_DONE) && if_done);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q      <= '0;
      instr_q     <= '0;
      if_start_q  <= '0;
      mem_start_q <= '0;
      mem_end_q   <= '0;
    end else begin
      if (cap_fetch) begin
        addr_q     <= fetch_addr;
        if_start_q <= now_q;
      end
      if (cap_gnt) mem_start_q <= now_q;
      if (cap_rvalid) begin
        instr_q   <= mem_rdata;
        mem_end_q <= now_q;
      end
    end
  end

  // A fetch can finish in the same cycle its data returns, so take rdata/now directly then
  always_comb begin
    push_rec.instr     = (state_q == WAIT_RVALID) ? mem_rdata : instr_q;
    push_rec.addr      = addr_q;
    push_rec.if_start  = if_start_q;
    push_rec.if_end    = now_q;
    push_rec.mem_start = mem_start_q;
    push_rec.mem_end   = (state_q == WAIT_RVALID) ? now_q : mem_end_q;
  end

  ryuki_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (push_rec),
    .pop_i   (trace_ready),
    .valid_o (fifo_valid),
    .head_o  (head_bits),
    .count_o (trace_count),
    .drop_o  (drop)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)                      ovf_q <= '0;
    else if (drop && (ovf_q != '1))  ovf_q <= ovf_q + OVF_WIDTH'(1);
  end

  assign head_rec        = head_bits;
  assign trace_valid     = fifo_valid;
  assign trace_instr     = head_rec.instr;
  assign trace_addr      = head_rec.addr;
  assign trace_if_start  = head_rec.if_start;
  assign trace_if_end    = head_rec.if_end;
  assign trace_mem_start = head_rec.mem_start;
  assign trace_mem_end   = head_rec.mem_end;
  assign trace_overflow  = ovf_q;

endmodule

// File: tb/tb_ryuki_if_tracer.sv
// Scoreboard bench for ryuki_if_tracer; a second 4-bit-time, 2-deep instance covers wrap and saturation.
module tb_ryuki_if_tracer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_s_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        if_done = 1'b0;
  logic        trace_ready = 1'b0;

  logic        trace_valid;
  logic [31:0] trace_instr, trace_addr;
  logic [31:0] trace_if_start, trace_if_end, trace_mem_start, trace_mem_end;
  logic [3:0]  trace_count;
  logic [15:0] trace_overflow;

  logic        s_valid;
  logic [31:0] s_instr, s_addr;
  logic [3:0]  s_if_start, s_if_end, s_mem_start, s_mem_end;
  logic [1:0]  s_count;
  logic [1:0]  s_overflow;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] ifs;
    logic [31:0] ife;
    logic [31:0] ms;
    logic [31:0] me;
  } rec_t;

  rec_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   tnow = 0;

  always #5 clk = ~clk;

  ryuki_if_tracer dut (
    .clk (clk), .rst_n (rst_n), .fetch_req (fetch_req), .fetch_addr (fetch_addr),
    .mem_gnt (mem_gnt), .mem_rvalid (mem_rvalid), .mem_rdata (mem_rdata), .if_done (if_done),
    .trace_valid (trace_valid), .trace_ready (trace_ready), .trace_instr (trace_instr),
    .trace_addr (trace_addr), .trace_if_start (trace_if_start), .trace_if_end (trace_if_end),
    .trace_mem_start (trace_mem_start), .trace_mem_end (trace_mem_end),
    .trace_count (trace_count), .trace_overflow (trace_overflow)
  );

  ryuki_if_tracer #(.TIME_WIDTH (4), .DEPTH (2), .OVF_WIDTH (2)) dut_s (
    .clk (clk), .rst_n (rst_s_n), .fetch_req (fetch_req), .fetch_addr (fetch_addr),
    .mem_gnt (mem_gnt), .mem_rvalid (mem_rvalid), .mem_rdata (mem_rdata), .if_done (if_done),
    .trace_valid (s_valid), .trace_ready (trace_ready), .trace_instr (s_instr),
    .trace_addr (s_addr), .trace_if_start (s_if_start), .trace_if_end (s_if_end),
    .trace_mem_start (s_mem_start), .trace_mem_end (s_mem_end),
    .trace_count (s_count), .trace_overflow (s_overflow)
  );

  // Scoreboard consumer: every accepted head record is checked against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && trace_valid && trace_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_record: got instr=%h addr=%h, required no record", trace_instr, trace_addr);
      end else begin
        rec_t e;
        e = sb.pop_front();
        if (trace_instr !== e.instr || trace_addr !== e.addr || trace_if_start !== e.ifs ||
            trace_if_end !== e.ife || trace_mem_start !== e.ms || trace_mem_end !== e.me) begin
          bad++;
          $display("FAIL record: got {%h %h if %0d-%0d mem %0d-%0d} required {%h %h if %0d-%0d mem %0d-%0d}",
                   trace_instr, trace_addr, trace_if_start, trace_if_end, trace_mem_start, trace_mem_end,
                   e.instr, e.addr, e.ifs, e.ife, e.ms, e.me);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      tnow++;
    end
  endtask

  task automatic do_reset(input bit main_en, input bit small_en);
    rst_n = 1'b0; rst_s_n = 1'b0;
    fetch_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; if_done = 1'b0; trace_ready = 1'b0;
    fetch_addr = '0; mem_rdata = '0;
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = main_en; rst_s_n = small_en;
    tnow = 0;
  endtask

  // gd: cycles from req to gnt; rd: gnt to rvalid (>=1); dd: rvalid to if_done
  task automatic fetch(input logic [31:0] addr, input logic [31:0] instr, input int gd, input int rd,
                       input int dd, input bit keep, input bit pop_at_done);
    rec_t r;
    r.addr = addr; r.instr = instr;
    fetch_req = 1'b1; fetch_addr = addr; r.ifs = tnow;
    if (gd == 0) begin mem_gnt = 1'b1; r.ms = tnow; end
    step(1);
    fetch_req = 1'b0; mem_gnt = 1'b0; fetch_addr = '0;
    if (gd > 0) begin
      step(gd - 1);
      mem_gnt = 1'b1; r.ms = tnow;
      step(1);
      mem_gnt = 1'b0;
    end
    step(rd - 1);
    mem_rvalid = 1'b1; mem_rdata = instr; r.me = tnow;
    if (dd == 0) begin
      if_done = 1'b1; r.ife = tnow;
      if (pop_at_done) trace_ready = 1'b1;
    end
    step(1);
    mem_rvalid = 1'b0; mem_rdata = '0; if_done = 1'b0;
    if (dd > 0) begin
      step(dd - 1);
      if_done = 1'b1; r.ife = tnow;
      if (pop_at_done) trace_ready = 1'b1;
      step(1);
      if_done = 1'b0;
    end
    if (pop_at_done) trace_ready = 1'b0;
    if (keep) sb.push_back(r);
  endtask

  task automatic drain();
    int i;
    trace_ready = 1'b1;
    for (i = 0; i < 200 && sb.size() != 0; i++) step(1);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d records outstanding, required 0", sb.size());
    end
    step(1);
    trace_ready = 1'b0;
    total++;
    if (trace_valid !== 1'b0 || trace_count !== 4'd0) begin
      bad++;
      $display("FAIL drained_empty: valid=%b count=%0d, required valid=0 count=0", trace_valid, trace_count);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b1, 1'b1);
    total++;
    if (trace_valid !== 1'b0 || trace_count !== 4'd0 || trace_overflow !== 16'd0) begin
      bad++;
      $display("FAIL reset_ctrl: valid=%b count=%0d ovf=%0d, required 0 0 0", trace_valid, trace_count, trace_overflow);
    end
    total++;
    if ({trace_instr, trace_addr, trace_if_start, trace_if_end, trace_mem_start, trace_mem_end} !== '0) begin
      bad++;
      $display("FAIL reset_data: instr=%h addr=%h, required all-zero head", trace_instr, trace_addr);
    end
    total++;
    if (s_valid !== 1'b0 || s_count !== 2'd0 || s_overflow !== 2'd0) begin
      bad++;
      $display("FAIL reset_small: valid=%b count=%0d ovf=%0d, required 0 0 0", s_valid, s_count, s_overflow);
    end
  endtask

  task automatic test_basic();
    do_reset(1'b1, 1'b0);
    step(3);
    fetch(32'h100, 32'h0000_0013, 0, 2, 2, 1'b1, 1'b0);
    total++;
    if (tnow != 8 || trace_valid !== 1'b1 || trace_count !== 4'd1) begin
      bad++;
      $display("FAIL basic_latency: cycle=%0d valid=%b count=%0d, required 8 1 1", tnow, trace_valid, trace_count);
    end
    drain();
  endtask

  task automatic test_delayed_gnt();
    do_reset(1'b1, 1'b0);
    step(4);
    fetch(32'h204, 32'hdead_beef, 2, 3, 0, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_overflow();
    do_reset(1'b1, 1'b0);
    for (int k = 0; k < 10; k++)
      fetch(32'h1000 + 32'(k * 4), 32'ha000_0000 + 32'(k), 0, 1, 0, k < 8, 1'b0);
    total++;
    if (trace_count !== 4'd8 || trace_overflow !== 16'd2) begin
      bad++;
      $display("FAIL overflow_count: count=%0d ovf=%0d, required 8 2", trace_count, trace_overflow);
    end
    drain();
  endtask

  task automatic test_full_pop_push();
    do_reset(1'b1, 1'b0);
    for (int k = 0; k < 8; k++)
      fetch(32'h2000 + 32'(k * 4), 32'hb000_0000 + 32'(k), k % 2, 1 + k % 3, k % 2, 1'b1, 1'b0);
    fetch(32'h3000, 32'hc0de_0009, 0, 1, 0, 1'b1, 1'b1);
    total++;
    if (trace_count !== 4'd8 || trace_overflow !== 16'd0) begin
      bad++;
      $display("FAIL full_pop_push: count=%0d ovf=%0d, required 8 0", trace_count, trace_overflow);
    end
    drain();
  endtask

  task automatic test_wrap_and_saturate();
    do_reset(1'b0, 1'b1);
    step(14);
    fetch(32'h400, 32'h1234_5678, 0, 2, 2, 1'b0, 1'b0);
    total++;
    if (s_valid !== 1'b1 || s_if_start !== 4'd14 || s_if_end !== 4'd2 ||
        s_mem_start !== 4'd14 || s_mem_end !== 4'd0 || s_addr !== 32'h400 || s_instr !== 32'h1234_5678) begin
      bad++;
      $display("FAIL wrap: valid=%b if %0d-%0d mem %0d-%0d addr=%h instr=%h, required 1 if 14-2 mem 14-0 400 12345678",
               s_valid, s_if_start, s_if_end, s_mem_start, s_mem_end, s_addr, s_instr);
    end
    for (int k = 0; k < 5; k++) fetch(32'h500 + 32'(k), 32'(k), 0, 1, 0, 1'b0, 1'b0);
    total++;
    if (s_count !== 2'd2 || s_overflow !== 2'd3) begin
      bad++;
      $display("FAIL ovf_saturate: count=%0d ovf=%0d, required 2 3", s_count, s_overflow);
    end
  endtask

  task automatic test_reset_midop();
    do_reset(1'b1, 1'b0);
    for (int k = 0; k < 10; k++) fetch(32'h600 + 32'(k * 4), 32'(k), 0, 1, 0, 1'b0, 1'b0);
    fetch_req = 1'b1; fetch_addr = 32'h700; mem_gnt = 1'b1;
    step(1);
    fetch_req = 1'b0; mem_gnt = 1'b0; fetch_addr = '0;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    total++;
    if (trace_valid !== 1'b0 || trace_count !== 4'd0 || trace_overflow !== 16'd0) begin
      bad++;
      $display("FAIL midop_reset: valid=%b count=%0d ovf=%0d, required 0 0 0", trace_valid, trace_count, trace_overflow);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h0bad_0bad; if_done = 1'b1;
    step(1);
    mem_rvalid = 1'b0; mem_rdata = '0; if_done = 1'b0;
    step(2);
    total++;
    if (trace_valid !== 1'b0 || trace_count !== 4'd0) begin
      bad++;
      $display("FAIL stale_rvalid: valid=%b count=%0d, required 0 0", trace_valid, trace_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1, 1'b0);
    trace_ready = 1'b1;
    for (int k = 0; k < 6; k++)
      fetch(32'h800 + 32'(k * 4), $urandom, $urandom_range(0, 2), $urandom_range(1, 3),
            $urandom_range(0, 2), 1'b1, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delayed_gnt();
    test_overflow();
    test_full_pop_push();
    test_wrap_and_saturate();
    test_reset_midop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
